mem_stage: RTL and testbench

Memory-access stage of the RISC-V pipeline, sitting directly downstream of the execute stage. It consumes execute's result bundle (destination register, write enable, ALU result/effective address) and either forwards it unchanged to writeback or performs a load/store over the byte-wide external memory bus. Multi-byte accesses are sequenced one byte per cycle, with a stall back to upstream. Load data is assembled little-endian and sign- or zero-extended before it is handed to writeback.

---
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the RISC-V pipeline.
//
// Takes the execute-stage result bundle and either forwards it to writeback
// (non-memory ops) or performs a load/store over a byte-wide memory bus, one
// byte per cycle, holding upstream with stall_o while busy. Load bytes are
// assembled little-endian and sign/zero-extended.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             execute bundle present
//   mop_i[3:0]          0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//   wa_i, we_i          destination register index / write request
//   wn_i[31:0]          ALU result (effective address for memory ops)
//   sdata_i[31:0]       store data
//   stall_o             upstream must hold its bundle
//   mem_a, mem_wr,      byte bus: address, write strobe, write byte
//   mem_dout, mem_din   read byte (valid the cycle after a read address)
//   valid_o, wa_o,      writeback bundle (one-cycle valid pulse)
//   we_o, wn_o
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  mop_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wn_i,
  input  logic [31:0] sdata_i,
  output logic        stall_o,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        valid_o,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic [31:0] wn_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  k_reg;
  logic [3:0]  mop_reg;
  logic [4:0]  wa_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] sdata_reg;
  logic [7:0]  byte_reg [0:3];

  logic        valid_reg;
  logic [4:0]  wa_o_reg;
  logic        we_o_reg;
  logic [31:0] wn_o_reg;

  // Decode of the latched op.
  logic        is_load, is_store;
  logic [1:0]  last_k;
  logic        in_mem;

  always_comb begin
    is_load  = (mop_reg >= 4'd1) && (mop_reg <= 4'd5);
    is_store = (mop_reg >= 4'd6) && (mop_reg <= 4'd8);
    case (mop_reg)
      4'd1, 4'd4, 4'd6: last_k = 2'd0;
      4'd2, 4'd5, 4'd7: last_k = 2'd1;
      default:          last_k = 2'd3;
    endcase
    in_mem = (mop_i >= 4'd1) && (mop_i <= 4'd8);
  end

  // Store byte lanes, and the load assembly where the final byte comes
  // straight from the bus in the WAIT cycle.
  logic [7:0] sbyte [0:3];
  logic [7:0] abyte [0:3];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign sbyte[gi] = sdata_reg[8*gi +: 8];
      assign abyte[gi] = (2'(gi) == last_k) ? mem_din : byte_reg[gi];
    end
  endgenerate

  logic [31:0] load_result;
  always_comb begin
    case (mop_reg)
      4'd1:    load_result = {{24{abyte[0][7]}}, abyte[0]};
      4'd2:    load_result = {{16{abyte[1][7]}}, abyte[1], abyte[0]};
      4'd4:    load_result = {24'd0, abyte[0]};
      4'd5:    load_result = {16'd0, abyte[1], abyte[0]};
      default: load_result = {abyte[3], abyte[2], abyte[1], abyte[0]};
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (valid_i && in_mem) state_next = S_BUS;
      S_BUS:   if (k_reg == last_k) state_next = is_load ? S_WAIT : S_IDLE;
      S_WAIT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from registered state only.
  always_comb begin
    stall_o  = (state_reg != S_IDLE);
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    if (state_reg == S_BUS) begin
      mem_a    = addr_reg + {30'd0, k_reg};
      mem_wr   = is_store;
      mem_dout = is_store ? sbyte[k_reg] : 8'd0;
    end
  end

  // Datapath: bundle latch, byte counter, load assembly, writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg     <= 2'd0;
      mop_reg   <= 4'd0;
      wa_reg    <= 5'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      sdata_reg <= 32'd0;
      for (int i = 0; i < 4; i++) byte_reg[i] <= 8'd0;
      valid_reg <= 1'b0;
      wa_o_reg  <= 5'd0;
      we_o_reg  <= 1'b0;
      wn_o_reg  <= 32'd0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (valid_i) begin
            mop_reg   <= mop_i;
            wa_reg    <= wa_i;
            we_reg    <= we_i;
            addr_reg  <= wn_i;
            sdata_reg <= sdata_i;
            k_reg     <= 2'd0;
            if (!in_mem) begin
              valid_reg <= 1'b1;
              wa_o_reg  <= wa_i;
              we_o_reg  <= we_i & (wa_i != 5'd0);
              wn_o_reg  <= wn_i;
            end
          end
        end
        S_BUS: begin
          k_reg <= k_reg + 2'd1;
          // The byte arriving now belongs to the address issued last cycle.
          if (is_load && k_reg != 2'd0) byte_reg[k_reg - 2'd1] <= mem_din;
          if (is_store && k_reg == last_k) begin
            valid_reg <= 1'b1;
            wa_o_reg  <= wa_reg;
            we_o_reg  <= 1'b0;
            wn_o_reg  <= 32'd0;
          end
        end
        S_WAIT: begin
          valid_reg <= 1'b1;
          wa_o_reg  <= wa_reg;
          we_o_reg  <= we_reg & (wa_reg != 5'd0);
          wn_o_reg  <= load_result;
        end
        default: ;
      endcase
    end
  end

  assign valid_o = valid_reg;
  assign wa_o    = wa_o_reg;
  assign we_o    = we_o_reg;
  assign wn_o    = wn_o_reg;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mop_i;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [31:0] wn_i;
  logic [31:0] sdata_i;
  logic        stall_o;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        valid_o;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wn_o;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mop_i(mop_i), .wa_i(wa_i),
    .we_i(we_i), .wn_i(wn_i), .sdata_i(sdata_i), .stall_o(stall_o),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .valid_o(valid_o), .wa_o(wa_o), .we_o(we_o), .wn_o(wn_o)
  );

  // 256-byte external memory, aliased on the low address byte.
  logic [7:0] mem [0:255];
  logic       pl_en;
  logic [7:0] pl_a, pl_d;
  always @(posedge clk) begin
    if (pl_en)       mem[pl_a] <= pl_d;
    else if (mem_wr) mem[mem_a[7:0]] <= mem_dout;
    mem_din <= mem[mem_a[7:0]];
  end

  typedef struct {
    logic [3:0]  mop;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wn;
    logic [31:0] sdata;
    logic [31:0] exp_wn;
    logic        exp_we;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t tbl [13];

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %h want %h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] m, input logic [4:0] a, input logic w,
                              input logic [31:0] n, input logic [31:0] s,
                              input logic [31:0] ew, input logic ee);
    vec_t v;
    v.mop = m; v.wa = a; v.we = w; v.wn = n; v.sdata = s; v.exp_wn = ew; v.exp_we = ee;
    return v;
  endfunction

  function automatic int nbytes(input logic [3:0] m);
    case (m)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [3:0] m);
    return (m >= 4'd1) && (m <= 4'd5);
  endfunction

  function automatic bit is_st(input logic [3:0] m);
    return (m >= 4'd6) && (m <= 4'd8);
  endfunction

  // Reference load: little-endian sum of N bytes, then signed reinterpretation.
  function automatic logic [31:0] load_ref(input logic [3:0] m, input logic [31:0] addr);
    longint v = 0;
    int n = nbytes(m);
    for (int i = 0; i < n; i++)
      v += longint'(mem[8'(addr + 32'(i))]) << (8 * i);
    if ((m == 4'd1 || m == 4'd2) && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One transaction: idle cycle, acceptance, bus trace, writeback pulse.
  task automatic run_op(input vec_t v, input string tag);
    int n, last;
    bit ld, st;
    logic [31:0] sh;
    n = nbytes(v.mop); ld = is_ld(v.mop); st = is_st(v.mop);
    last = st ? n : (ld ? n + 1 : 0);
    @(posedge clk); #1;
    valid_i = 1'b1; mop_i = v.mop; wa_i = v.wa; we_i = v.we; wn_i = v.wn; sdata_i = v.sdata;
    @(negedge clk);
    chk(tag, "idle_valid", {31'd0, valid_o}, 32'd0);
    chk(tag, "idle_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; mop_i = 4'($urandom); wn_i = $urandom;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      chk(tag, "busy_stall", {31'd0, stall_o}, 32'd1);
      chk(tag, "busy_valid", {31'd0, valid_o}, 32'd0);
      if (c <= n) begin
        sh = v.sdata >> (8 * (c - 1));
        chk(tag, "mem_a", mem_a, v.wn + 32'(c - 1));
        chk(tag, "mem_wr", {31'd0, mem_wr}, {31'd0, st});
        chk(tag, "mem_dout", {24'd0, mem_dout}, st ? {24'd0, sh[7:0]} : 32'd0);
      end else begin
        chk(tag, "wait_a", mem_a, 32'd0);
        chk(tag, "wait_wr", {31'd0, mem_wr}, 32'd0);
      end
    end
    if (last > 0) @(posedge clk);
    @(negedge clk);
    chk(tag, "valid_o", {31'd0, valid_o}, 32'd1);
    chk(tag, "stall_done", {31'd0, stall_o}, 32'd0);
    chk(tag, "wa_o", {27'd0, wa_o}, {27'd0, v.wa});
    chk(tag, "we_o", {31'd0, we_o}, {31'd0, v.exp_we});
    chk(tag, "wn_o", wn_o, v.exp_wn);
    $display("%s: mop=%0d addr=%h wa=%0d -> wn_o=%h we_o=%b", tag, v.mop, v.wn, v.wa, wn_o, we_o);
  endtask

  initial begin
    vec_t r;
    logic [7:0] keep82;
    rst = 1'b1; valid_i = 1'b0; mop_i = 4'd0; wa_i = 5'd0; we_i = 1'b0;
    wn_i = 32'd0; sdata_i = 32'd0; pl_en = 1'b0; pl_a = 8'd0; pl_d = 8'd0;

    tbl[0]  = mk(4'd0,  5'd5,  1'b1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1);
    tbl[1]  = mk(4'd1,  5'd3,  1'b1, 32'h00000007, 32'h0,        32'hFFFFFF80, 1'b1);
    tbl[2]  = mk(4'd4,  5'd3,  1'b1, 32'h00000007, 32'h0,        32'h00000080, 1'b1);
    tbl[3]  = mk(4'd2,  5'd6,  1'b1, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 1'b1);
    tbl[4]  = mk(4'd5,  5'd6,  1'b0, 32'hFFFFFFFF, 32'h0,        32'h0000FFFE, 1'b0);
    tbl[5]  = mk(4'd8,  5'd7,  1'b1, 32'h00000100, 32'h11223344, 32'h0,        1'b0);
    tbl[6]  = mk(4'd3,  5'd0,  1'b1, 32'h00000100, 32'h0,        32'h11223344, 1'b0);
    tbl[7]  = mk(4'd12, 5'd4,  1'b1, 32'h12345678, 32'h0,        32'h12345678, 1'b1);
    tbl[8]  = mk(4'd6,  5'd9,  1'b1, 32'h00000020, 32'hABCDEF5A, 32'h0,        1'b0);
    tbl[9]  = mk(4'd4,  5'd10, 1'b1, 32'h00000020, 32'h0,        32'h0000005A, 1'b1);
    tbl[10] = mk(4'd7,  5'd11, 1'b1, 32'h00000030, 32'h00008001, 32'h0,        1'b0);
    tbl[11] = mk(4'd2,  5'd12, 1'b1, 32'h00000030, 32'h0,        32'hFFFF8001, 1'b1);
    tbl[12] = mk(4'd0,  5'd0,  1'b1, 32'h00000055, 32'h0,        32'h00000055, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", "valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset", "wa_o", {27'd0, wa_o}, 32'd0);
    chk("reset", "we_o", {31'd0, we_o}, 32'd0);
    chk("reset", "wn_o", wn_o, 32'd0);
    chk("reset", "stall_o", {31'd0, stall_o}, 32'd0);
    chk("reset", "mem_a", mem_a, 32'd0);
    chk("reset", "mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("reset", "mem_dout", {24'd0, mem_dout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h07, 8'h80);
    poke(8'hFF, 8'hFE);
    poke(8'h00, 8'hFF);

    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // LW to x0 with a non-memory bundle held under stall: accepted in the
    // valid_o cycle, its own pulse one cycle later.
    @(posedge clk); #1;
    valid_i = 1'b1; mop_i = 4'd3; wa_i = 5'd0; we_i = 1'b1; wn_i = 32'h00000100;
    @(posedge clk); #1;
    mop_i = 4'd0; wa_i = 5'd17; we_i = 1'b1; wn_i = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      chk("b2b", "stall", {31'd0, stall_o}, 32'd1);
      chk("b2b", "valid_early", {31'd0, valid_o}, 32'd0);
    end
    @(posedge clk); @(negedge clk);
    chk("b2b", "lw_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b", "lw_we", {31'd0, we_o}, 32'd0);
    chk("b2b", "lw_wn", wn_o, 32'h11223344);
    chk("b2b", "lw_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("b2b", "alu_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b", "alu_wa", {27'd0, wa_o}, 32'd17);
    chk("b2b", "alu_wn", wn_o, 32'hCAFEF00D);
    chk("b2b", "alu_we", {31'd0, we_o}, 32'd1);
    $display("b2b: LW x0 then ALU x17 back-to-back");

    // Reset in cycle T+2 of an SW aborts the access.
    keep82 = mem[8'h82];
    @(posedge clk); #1;
    valid_i = 1'b1; mop_i = 4'd8; wa_i = 5'd2; we_i = 1'b1; wn_i = 32'h00000180; sdata_i = 32'hA1B2C3D4;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("rstmid", "wr_t1", {31'd0, mem_wr}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid", "wr_t3", {31'd0, mem_wr}, 32'd0);
    chk("rstmid", "stall_t3", {31'd0, stall_o}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk("rstmid", "no_valid", {31'd0, valid_o}, 32'd0);
      chk("rstmid", "no_wr", {31'd0, mem_wr}, 32'd0);
      @(negedge clk);
    end
    chk("rstmid", "byte0", {24'd0, mem[8'h80]}, 32'h000000D4);
    chk("rstmid", "byte1", {24'd0, mem[8'h81]}, 32'h000000C3);
    chk("rstmid", "byte2", {24'd0, mem[8'h82]}, {24'd0, keep82});
    $display("rstmid: SW aborted by reset");
    run_op(mk(4'd6, 5'd8, 1'b1, 32'h00000090, 32'h00000077, 32'h0, 1'b0), "sb_after_rst");
    run_op(mk(4'd4, 5'd8, 1'b1, 32'h00000090, 32'h0, 32'h00000077, 1'b1), "lbu_after_rst");

    // Randomized bundles against the reference model.
    for (int i = 0; i < 60; i++) begin
      r.mop = 4'($urandom_range(0, 15));
      r.wa = 5'($urandom); r.we = 1'($urandom);
      r.wn = $urandom; r.sdata = $urandom;
      if (is_ld(r.mop)) begin
        r.exp_wn = load_ref(r.mop, r.wn);
        r.exp_we = r.we & (r.wa != 5'd0);
      end else if (is_st(r.mop)) begin
        r.exp_wn = 32'd0;
        r.exp_we = 1'b0;
      end else begin
        r.exp_wn = r.wn;
        r.exp_we = r.we & (r.wa != 5'd0);
      end
      run_op(r, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
